// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the IF-stage branch target predictor.
// History width and encodings depend on BHT_TWO_BIT_EN:
//   defined   -> 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T)
//   undefined -> 1-bit last-outcome history (0 NT, 1 T)
package branch_target_predictor_pkg;

  localparam int ENTRY_BITS_DEF = 6;
  localparam int CNT_WIDTH_DEF  = 32;

  // Resolved branch type carried down to EX; JAL/JALR arrive as NOBRANCH.
  typedef enum logic [2:0] {
    BT_NOBRANCH = 3'd0,
    BT_BEQ      = 3'd1,
    BT_BNE      = 3'd2,
    BT_BLT      = 3'd3,
    BT_BGE      = 3'd4,
    BT_BLTU     = 3'd5,
    BT_BGEU     = 3'd6
  } branch_type_e;

`ifdef BHT_TWO_BIT_EN
  localparam int HIST_W = 2;
  typedef logic [HIST_W-1:0] hist_t;
  localparam hist_t HIST_MIN   = 2'b00;  // strong not-taken
  localparam hist_t HIST_MAX   = 2'b11;  // strong taken
  localparam hist_t HIST_ALLOC = 2'b10;  // weak taken
`else
  localparam int HIST_W = 1;
  typedef logic [HIST_W-1:0] hist_t;
  localparam hist_t HIST_MIN   = 1'b0;
  localparam hist_t HIST_MAX   = 1'b1;
  localparam hist_t HIST_ALLOC = 1'b1;
`endif

  localparam hist_t HIST_RESET = HIST_MIN;

  // The prediction is always the history MSB, for either width.
  function automatic logic hist_taken(hist_t h);
    return h[HIST_W-1];
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter_update.sv
// Next-state of one BTB history field given the resolved outcome.
// BHT_TWO_BIT_EN selects a 2-bit saturating counter; otherwise the
// field simply records the last outcome.
module sat_counter_update
  import branch_target_predictor_pkg::*;
(
  input  logic [HIST_W-1:0] cur,
  input  logic              taken,
  output logic [HIST_W-1:0] nxt
);

`ifdef BHT_TWO_BIT_EN
  // Saturating step towards the resolved direction.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != HIST_MAX) nxt = cur + hist_t'(1);
    end else begin
      if (cur != HIST_MIN) nxt = cur - hist_t'(1);
    end
  end
`else
  // Only the latest outcome matters; the old value is not consulted.
  logic unused_cur;
  assign unused_cur = ^cur;

  // Record the latest outcome.
  always_comb begin
    nxt = taken ? HIST_MAX : HIST_MIN;
  end
`endif

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer for the IF stage.
// Lookup of PCF is combinational; the EX-stage resolution updates the
// table at the clock edge and raises MispredictE for the hazard unit.
// History width follows BHT_TWO_BIT_EN (see branch_target_predictor_pkg).
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = ENTRY_BITS_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          PCF,
  output logic                 PredTakenF,
  output logic [31:0]          PredTargetF,
  input  logic                 UpdateEn,
  input  logic [31:0]          PCE,
  input  logic [2:0]           BranchTypeE,
  input  logic                 BranchE,
  input  logic [31:0]          BranchTargetE,
  input  logic                 PredTakenE,
  input  logic [31:0]          PredTargetE,
  output logic                 MispredictE,
  output logic [31:0]          CorrectPCE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int TAG_BITS    = 30 - ENTRY_BITS;
  localparam int NUM_ENTRIES = 1 << ENTRY_BITS;

  logic                valid_q  [NUM_ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [NUM_ENTRIES];
  logic [31:0]         target_q [NUM_ENTRIES];
  hist_t               hist_q   [NUM_ENTRIES];

  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  upd_e;
  hist_t                 hist_e, hist_nxt;
  logic [31:0]           pce_plus4;

  // Instructions are word aligned, so the low PC bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];

  // Only conditional branches in a live EX slot train the table.
  assign upd_e     = UpdateEn & (BranchTypeE != BT_NOBRANCH);
  assign pce_plus4 = PCE + 32'd4;

  // Fetch-side lookup; reads the registered table, so a same-cycle
  // update to this index shows up only on the following cycle.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && hist_taken(hist_q[idx_f]);
    PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;
  end

  // EX-side view of the entry being trained.
  always_comb begin
    hit_e  = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    hist_e = hist_q[idx_e];
  end

  sat_counter_update u_hist_next (
    .cur   (hist_e),
    .taken (BranchE),
    .nxt   (hist_nxt)
  );

  // Compare the carried prediction with the resolved outcome.
  always_comb begin
    MispredictE = 1'b0;
    CorrectPCE  = pce_plus4;
    if (upd_e) begin
      MispredictE = (PredTakenE != BranchE) ||
                    (PredTakenE && BranchE && (PredTargetE != BranchTargetE));
      if (BranchE) CorrectPCE = BranchTargetE;
    end
  end

  // Table training: hits adjust history (and retarget when taken),
  // taken misses evict whatever occupied the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        hist_q[i]  <= HIST_RESET;
      end
    end else if (upd_e) begin
      if (hit_e) begin
        hist_q[idx_e] <= hist_nxt;
        if (BranchE) target_q[idx_e] <= BranchTargetE;
      end else if (BranchE) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= BranchTargetE;
        hist_q[idx_e]   <= HIST_ALLOC;
      end
    end
  end

  // Statistics counters; both wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (upd_e) begin
      BranchCount <= BranchCount + CNT_WIDTH'(1);
      if (MispredictE) MispredCount <= MispredCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized bench for branch_target_predictor, checked
// against a table model that stores whole branch PCs and integer history.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateEn;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCF           (PCF),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF),
    .UpdateEn      (UpdateEn),
    .PCE           (PCE),
    .BranchTypeE   (BranchTypeE),
    .BranchE       (BranchE),
    .BranchTargetE (BranchTargetE),
    .PredTakenE    (PredTakenE),
    .PredTargetE   (PredTargetE),
    .MispredictE   (MispredictE),
    .CorrectPCE    (CorrectPCE),
    .BranchCount   (BranchCount),
    .MispredCount  (MispredCount)
  );

`ifdef BHT_TWO_BIT_EN
  localparam int HMAX = 3, HALLOC = 2, HTHR = 2;
  localparam bit HYST_KEEPS_TAKEN = 1'b1;
`else
  localparam int HMAX = 1, HALLOC = 1, HTHR = 1;
  localparam bit HYST_KEEPS_TAKEN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: 64 slots holding the full branch PC that owns them.
  bit          m_valid [64];
  bit [31:0]   m_pc    [64];
  bit [31:0]   m_tgt   [64];
  int          m_hist  [64];
  bit [31:0]   m_bc, m_mc;

  // Values observed in the most recent cycle.
  logic        o_ptf, o_mis;
  logic [31:0] o_ptg, o_cpc, o_bc, o_mc;

  function automatic int m_idx(bit [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(bit [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && ((m_pc[i] >> 8) == (pc >> 8));
  endfunction

  function automatic bit m_taken(bit [31:0] pc);
    return m_hit(pc) && (m_hist[m_idx(pc)] >= HTHR);
  endfunction

  function automatic bit [31:0] m_target(bit [31:0] pc);
    return m_taken(pc) ? m_tgt[m_idx(pc)] : 32'd0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_hist[i]  = 0;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare every output with the model, then advance the model.
  task automatic cycle(input bit rst, input bit [31:0] pcf, input bit ue,
                       input bit [31:0] pce, input bit [2:0] bt, input bit be,
                       input bit [31:0] btgt, input bit pte, input bit [31:0] ptgt);
    bit        isbr, mis;
    bit [31:0] cpc;
    int        i;
    @(negedge clk);
    rst_n = !rst; PCF = pcf; UpdateEn = ue; PCE = pce; BranchTypeE = bt;
    BranchE = be; BranchTargetE = btgt; PredTakenE = pte; PredTargetE = ptgt;
    #1;
    o_ptf = PredTakenF; o_ptg = PredTargetF; o_mis = MispredictE;
    o_cpc = CorrectPCE; o_bc = BranchCount; o_mc = MispredCount;
    isbr = ue && (bt != 3'd0);
    mis  = isbr && ((pte != be) || (pte && be && (ptgt != btgt)));
    cpc  = (isbr && be) ? btgt : pce + 32'd4;
    chk("pred_taken", {31'd0, o_ptf}, {31'd0, m_taken(pcf)});
    chk("pred_target", o_ptg, m_target(pcf));
    chk("mispredict", {31'd0, o_mis}, {31'd0, mis});
    chk("correct_pc", o_cpc, cpc);
    chk("branch_count", o_bc, m_bc);
    chk("mispred_count", o_mc, m_mc);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (isbr) begin
      m_bc++;
      if (mis) m_mc++;
      i = m_idx(pce);
      if (m_hit(pce)) begin
        m_hist[i] = be ? ((m_hist[i] + 1 > HMAX) ? HMAX : m_hist[i] + 1)
                       : ((m_hist[i] - 1 < 0) ? 0 : m_hist[i] - 1);
        if (be) m_tgt[i] = btgt;
      end else if (be) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = pce;
        m_tgt[i]   = btgt;
        m_hist[i]  = HALLOC;
      end
    end
  endtask

  initial begin
    bit [31:0] pool [7];
    bit [31:0] pcf, pce, btgt, ptgt;
    bit        pte, be, ue, rst;
    bit [2:0]  bt;

    rst_n = 1'b0; PCF = 0; UpdateEn = 0; PCE = 0; BranchTypeE = 0;
    BranchE = 0; BranchTargetE = 0; PredTakenE = 0; PredTargetE = 0;
    repeat (3) @(posedge clk);
    m_reset();

    // Reset state
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pred_taken", {31'd0, o_ptf}, 32'd0);
    chk("rst_pred_target", o_ptg, 32'd0);
    chk("rst_branch_count", o_bc, 32'd0);

    // First taken BEQ allocates; same-cycle lookup sees the old (empty) entry
    cycle(0, 32'h100, 1, 32'h100, 3'd1, 1, 32'h80, 0, 0);
    chk("alloc_mispredict", {31'd0, o_mis}, 32'd1);
    chk("alloc_correct_pc", o_cpc, 32'h80);
    chk("same_cycle_old", {31'd0, o_ptf}, 32'd0);
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("alloc_pred_taken", {31'd0, o_ptf}, 32'd1);
    chk("alloc_pred_target", o_ptg, 32'h80);
    chk("alloc_mispred_count", o_mc, 32'd1);

    // Three more taken, then one not-taken: hysteresis depends on history width
    repeat (3) cycle(0, 32'h100, 1, 32'h100, 3'd1, 1, 32'h80,
                     m_taken(32'h100), m_target(32'h100));
    cycle(0, 32'h100, 1, 32'h100, 3'd1, 0, 32'h80, m_taken(32'h100), m_target(32'h100));
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("hysteresis_pred", {31'd0, o_ptf}, {31'd0, HYST_KEEPS_TAKEN});

    // Aliasing: 0x200 maps to the same slot and evicts 0x100
    cycle(0, 32'h200, 1, 32'h200, 3'd2, 1, 32'h300, 0, 0);
    chk("alias_same_cycle", {31'd0, o_ptf}, 32'd0);
    cycle(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("alias_old_miss", {31'd0, o_ptf}, 32'd0);
    cycle(0, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    chk("alias_new_taken", {31'd0, o_ptf}, 32'd1);
    chk("alias_new_target", o_ptg, 32'h300);

    // Not-taken BNE that was predicted not-taken: no flush, fall through, no allocation
    cycle(0, 32'h40, 1, 32'h40, 3'd2, 0, 32'h1234, 0, 0);
    chk("nt_mispredict", {31'd0, o_mis}, 32'd0);
    chk("nt_correct_pc", o_cpc, 32'h44);
    cycle(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    chk("nt_no_alloc", {31'd0, o_ptf}, 32'd0);
    chk("nt_branch_count", o_bc, 32'd7);

    // PC+4 wraps at the top of the address space
    cycle(0, 32'h0, 1, 32'hFFFF_FFFC, 3'd3, 0, 32'h10, 0, 0);
    chk("wrap_correct_pc", o_cpc, 32'h0);

    // Stalled EX slot: nothing trains, no flush
    cycle(0, 32'h40, 0, 32'h40, 3'd1, 1, 32'h88, 0, 0);
    chk("stall_mispredict", {31'd0, o_mis}, 32'd0);
    chk("stall_correct_pc", o_cpc, 32'h44);
    cycle(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_no_alloc", {31'd0, o_ptf}, 32'd0);
    chk("stall_branch_count", o_bc, 32'd8);
    chk("stall_mispred_count", o_mc, 32'd3);

    // Reset in the same cycle as an update discards the update
    cycle(1, 32'h200, 1, 32'h500, 3'd1, 1, 32'h600, 0, 0);
    cycle(0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_discard", {31'd0, o_ptf}, 32'd0);
    chk("midrst_branch_count", o_bc, 32'd0);
    chk("midrst_mispred_count", o_mc, 32'd0);
    cycle(0, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_table_clear", {31'd0, o_ptf}, 32'd0);

    // Randomized traffic over a small PC pool so hits and aliasing are frequent
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h104;
    pool[3] = 32'h40;  pool[4] = 32'h1000_0100; pool[5] = 32'hFFFF_FFFC;
    pool[6] = 32'h300;
    for (int n = 0; n < 500; n++) begin
      pcf  = (n % 5 == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 6)];
      pce  = pool[$urandom_range(0, 6)];
      bt   = 3'($urandom_range(0, 6));
      be   = 1'($urandom_range(0, 1));
      ue   = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 99) == 0);
      btgt = ($urandom_range(0, 1) != 0) ? (32'h80 << $urandom_range(0, 3))
                                        : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 4) == 0) begin
        pte  = 1'($urandom_range(0, 1));
        ptgt = $urandom & 32'hFFFF_FFFC;
      end else begin
        pte  = m_taken(pce);
        ptgt = m_target(pce);
      end
      cycle(rst, pcf, ue, pce, bt, be, btgt, pte, ptgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
